tube_par_agent: RTL and testbench



---
 rtl/tube_pkg.sv | 42 ++++
 rtl/tube_par_agent_if.sv | 13 +
 rtl/tube_par_rx_hold.sv | 25 ++
 rtl/tube_par_agent.sv | 134 +++++++++++++
 tb/tb_tube_par_agent.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared types, status bit positions and address helpers for the tube parasite agent
package tube_pkg;

    typedef enum logic [2:0] {
        S_STAT,
        S_STAT_GAP,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_IDLE
    } tube_state_t;

    localparam int TUBE_STAT_AVAIL_BIT = 7;
    localparam int TUBE_STAT_SPACE_BIT = 6;

    function automatic logic [2:0] stat_addr(input logic [1:0] ch);
        return {ch, 1'b0};
    endfunction

    function automatic logic [2:0] data_addr(input logic [1:0] ch);
        return {ch, 1'b1};
    endfunction

    // Next enabled channel after ch, searching upward with wrap; returns ch itself if it is the only one.
    function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] ch);
        logic [1:0] res;
        logic       found;
        logic [1:0] c;
        res   = ch;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            c = ch + 2'(i);
            if (!found && mask[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tube_par_agent_if.sv
// rtl/tube_par_agent_if.sv - parasite-side tube register port
interface tube_par_agent_if;
    logic       tube_ncs;
    logic       tube_read;
    logic [2:0] tube_addr;
    logic [7:0] tube_wdata;
    logic [7:0] tube_rdata;

    modport master (output tube_ncs, output tube_read, output tube_addr, output tube_wdata,
                    input tube_rdata);
    modport slave  (input tube_ncs, input tube_read, input tube_addr, input tube_wdata,
                    output tube_rdata);
endinterface

// File: rtl/tube_par_rx_hold.sv
// rtl/tube_par_rx_hold.sv - one-entry byte holding register with valid/ready
module tube_par_rx_hold (
    input  logic       par_clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready
);

    // load is only raised while the entry is empty, so it never races the consume.
    always_ff @(posedge par_clk) begin
        if (clr) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tube_par_agent.sv
// rtl/tube_par_agent.sv - round-robin parasite bus master polling the four tube register pairs
module tube_par_agent
    import tube_pkg::*;
#(
    parameter logic [3:0] POLL_MASK = 4'b1111,
    parameter int         IDLE_GAP  = 0
) (
    input  logic                   par_clk,
    input  logic                   par_rst,
    input  logic                   tube_nrst,
    tube_par_agent_if.master       tube,
    output logic [31:0]            rx_data,
    output logic [3:0]             rx_valid,
    input  logic [3:0]             rx_ready,
    input  logic [31:0]            tx_data,
    input  logic [3:0]             tx_valid,
    output logic [3:0]             tx_ready
);

    localparam logic [1:0] FIRST_CH = next_ch(POLL_MASK, 2'd3);

    tube_state_t state;
    logic [1:0]  ch;
    logic        space_q;
    logic [3:0]  idle_cnt;

    logic        rst_any;
    logic        avail;
    logic        space;
    logic        rd_go;
    logic        wr_go;
    logic [1:0]  nxt;
    logic        wrap;
    logic [7:0]  tx_byte;
    logic [3:0]  rx_load;

    assign rst_any = par_rst || !tube_nrst;
    assign avail   = tube.tube_rdata[TUBE_STAT_AVAIL_BIT];
    assign space   = tube.tube_rdata[TUBE_STAT_SPACE_BIT];
    assign tx_byte = tx_data[{ch, 3'b000} +: 8];
    assign nxt     = next_ch(POLL_MASK, ch);
    assign wrap    = (nxt <= ch);

    assign rd_go = (state == S_STAT_GAP) && avail && !rx_valid[ch];
    assign wr_go = !rst_any && tx_valid[ch] &&
                   (((state == S_STAT_GAP) && !rd_go && space) ||
                    ((state == S_RD_GAP) && space_q));

    assign tx_ready = wr_go ? (4'b0001 << ch) : 4'b0000;
    assign rx_load  = (!rst_any && state == S_RD_GAP) ? (4'b0001 << ch) : 4'b0000;

    for (genvar g = 0; g < 4; g++) begin : g_rx
        tube_par_rx_hold u_hold (
            .par_clk   (par_clk),
            .clr       (rst_any),
            .load      (rx_load[g]),
            .load_data (tube.tube_rdata),
            .data      (rx_data[8*g +: 8]),
            .valid     (rx_valid[g]),
            .ready     (rx_ready[g])
        );
    end

    // Bus outputs are set on entry to each state; gap and idle cycles fall back to ncs=1, read=1.
    always_ff @(posedge par_clk) begin
        if (rst_any) begin
            state           <= S_STAT;
            ch              <= FIRST_CH;
            space_q         <= 1'b0;
            idle_cnt        <= 4'd0;
            tube.tube_ncs   <= 1'b1;
            tube.tube_read  <= 1'b1;
            tube.tube_addr  <= 3'd0;
            tube.tube_wdata <= 8'h00;
        end else begin
            tube.tube_ncs  <= 1'b1;
            tube.tube_read <= 1'b1;
            case (state)
                S_STAT: begin
                    if (POLL_MASK == 4'b0000) begin
                        state <= S_IDLE;
                    end else if (tube.tube_ncs) begin
                        // first cycle out of reset: issue the status read now
                        tube.tube_ncs  <= 1'b0;
                        tube.tube_addr <= stat_addr(ch);
                    end else begin
                        state <= S_STAT_GAP;
                    end
                end
                S_RD:     state <= S_RD_GAP;
                S_WR:     state <= S_WR_GAP;
                S_STAT_GAP, S_RD_GAP, S_WR_GAP: begin
                    if (state == S_STAT_GAP) begin
                        space_q <= space;
                    end
                    if (rd_go) begin
                        state          <= S_RD;
                        tube.tube_ncs  <= 1'b0;
                        tube.tube_addr <= data_addr(ch);
                    end else if (wr_go) begin
                        state           <= S_WR;
                        tube.tube_ncs   <= 1'b0;
                        tube.tube_read  <= 1'b0;
                        tube.tube_addr  <= data_addr(ch);
                        tube.tube_wdata <= tx_byte;
                    end else begin
                        ch <= nxt;
                        if (wrap && IDLE_GAP > 0) begin
                            state    <= S_IDLE;
                            idle_cnt <= 4'(IDLE_GAP - 1);
                        end else begin
                            state          <= S_STAT;
                            tube.tube_ncs  <= 1'b0;
                            tube.tube_addr <= stat_addr(nxt);
                        end
                    end
                end
                S_IDLE: begin
                    if (POLL_MASK != 4'b0000) begin
                        if (idle_cnt == 4'd0) begin
                            state          <= S_STAT;
                            tube.tube_ncs  <= 1'b0;
                            tube.tube_addr <= stat_addr(ch);
                        end else begin
                            idle_cnt <= idle_cnt - 4'd1;
                        end
                    end
                end
                default: state <= S_STAT;
            endcase
        end
    end

endmodule

// File: tb/tb_tube_par_agent.sv
// tb/tb_tube_par_agent.sv - bench for tube_par_agent: two configurations against a visit-level model
module tb_tube_par_agent;

    localparam logic [3:0] M0 = 4'b1111;
    localparam int         G0 = 0;
    localparam logic [3:0] M1 = 4'b0101;
    localparam int         G1 = 3;
    localparam int         K  = 16;

    typedef struct packed {
        logic [2:0]  addr;
        logic        rd;
        logic [7:0]  wd;
        logic [3:0]  rdy;
        logic [31:0] t;
    } acc_t;

    logic        par_clk = 1'b0;
    logic        par_rst;
    logic        tube_nrst;
    logic [31:0] tx_data;
    logic [3:0]  tx_valid;
    logic [3:0]  rx_ready;
    logic [31:0] rx_data0, rx_data1;
    logic [3:0]  rx_valid0, rx_valid1, tx_ready0, tx_ready1;

    logic [7:0]  stat [4];
    logic [7:0]  dbyte[4];

    acc_t        obs0[$], obs1[$], exp0[$], exp1[$], mq[$], oq[$], eq[$];
    logic [9:0]  rxl0[$], rxl1[$], rl[$];
    logic [3:0]  prev_rdy0 = 4'b0, prev_rdy1 = 4'b0;
    logic [3:0]  rs, rseen0, rseen1;
    int          stray0 = 0, stray1 = 0;
    int          cyc = 0;
    int          vectors, miscompares;

    always #5 par_clk = ~par_clk;
    always @(posedge par_clk) cyc <= cyc + 1;

    tube_par_agent_if bus0();
    tube_par_agent_if bus1();

    tube_par_agent #(.POLL_MASK(M0), .IDLE_GAP(G0)) dut0 (
        .par_clk(par_clk), .par_rst(par_rst), .tube_nrst(tube_nrst), .tube(bus0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready0));

    tube_par_agent #(.POLL_MASK(M1), .IDLE_GAP(G1)) dut1 (
        .par_clk(par_clk), .par_rst(par_rst), .tube_nrst(tube_nrst), .tube(bus1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1));

    function automatic acc_t mk(input logic [2:0] a, input logic r, input logic [7:0] w,
                                input logic [3:0] y, input logic [31:0] t);
        acc_t x;
        x.addr = a; x.rd = r; x.wd = w; x.rdy = y; x.t = t;
        return x;
    endfunction

    function automatic logic [7:0] resp(input logic [2:0] a);
        return a[0] ? dbyte[a[2:1]] : stat[a[2:1]];
    endfunction

    // Tube responder and bus logger, one per DUT.
    always @(negedge par_clk) begin
        if (prev_rdy0 != 4'b0 && !(bus0.tube_ncs == 1'b0 && bus0.tube_read == 1'b0)) stray0++;
        if (bus0.tube_ncs == 1'b0) begin
            obs0.push_back(mk(bus0.tube_addr, bus0.tube_read,
                              bus0.tube_read ? 8'h00 : bus0.tube_wdata, prev_rdy0, cyc));
            if (bus0.tube_read) bus0.tube_rdata = resp(bus0.tube_addr);
        end
        for (int n = 0; n < 4; n++)
            if (rx_valid0[n] && rx_ready[n]) rxl0.push_back({2'(n), rx_data0[8*n +: 8]});
        prev_rdy0 = tx_ready0;
    end

    always @(negedge par_clk) begin
        if (prev_rdy1 != 4'b0 && !(bus1.tube_ncs == 1'b0 && bus1.tube_read == 1'b0)) stray1++;
        if (bus1.tube_ncs == 1'b0) begin
            obs1.push_back(mk(bus1.tube_addr, bus1.tube_read,
                              bus1.tube_read ? 8'h00 : bus1.tube_wdata, prev_rdy1, cyc));
            if (bus1.tube_read) bus1.tube_rdata = resp(bus1.tube_addr);
        end
        for (int n = 0; n < 4; n++)
            if (rx_valid1[n] && rx_ready[n]) rxl1.push_back({2'(n), rx_data1[8*n +: 8]});
        prev_rdy1 = tx_ready1;
    end

    task automatic tick();
        @(posedge par_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic reset_dut(input bit via_nrst);
        if (via_nrst) begin
            tube_nrst = 1'b0;
            repeat (5) tick();
        end else begin
            par_rst = 1'b1;
            tick();
        end
        chk("reset dut0", {bus0.tube_ncs, bus0.tube_read, bus0.tube_addr, bus0.tube_wdata,
                           rx_valid0, tx_ready0, rx_data0},
            {1'b1, 1'b1, 3'd0, 8'h00, 4'h0, 4'h0, 32'h0});
        chk("reset dut1", {bus1.tube_ncs, bus1.tube_read, bus1.tube_addr, bus1.tube_wdata,
                           rx_valid1, tx_ready1, rx_data1},
            {1'b1, 1'b1, 3'd0, 8'h00, 4'h0, 4'h0, 32'h0});
    endtask

    task automatic release_rst();
        par_rst   = 1'b0;
        tube_nrst = 1'b1;
        obs0 = {}; obs1 = {}; rxl0 = {}; rxl1 = {};
        stray0 = 0; stray1 = 0;
    endtask

    // Visit-level model: status read, optional data read, optional write, then next enabled channel.
    task automatic build(input logic [3:0] mask, input int gap);
        logic [3:0] rxf;
        int n, nx, t;
        mq = {}; rs = 4'b0; rxf = 4'b0; t = 0; n = 0;
        while (!mask[n]) n++;
        while (mq.size() < K) begin
            mq.push_back(mk(3'(2*n), 1'b1, 8'h00, 4'b0, 32'(t)));
            t += 2;
            if (stat[n][7] && !rxf[n]) begin
                if (mq.size() <= K - 2) rs[n] = 1'b1;
                mq.push_back(mk(3'(2*n+1), 1'b1, 8'h00, 4'b0, 32'(t)));
                t += 2;
                rxf[n] = !rx_ready[n];
            end
            if (stat[n][6] && tx_valid[n]) begin
                mq.push_back(mk(3'(2*n+1), 1'b0, tx_data[8*n +: 8], 4'b0001 << n, 32'(t)));
                t += 2;
            end
            nx = n;
            do nx = (nx + 1) % 4; while (!mask[nx]);
            if (nx <= n) t += gap;
            n = nx;
        end
    endtask

    initial begin
        int b;
        acc_t a;
        logic [3:0]  rxv;
        logic [31:0] rxd;
        int st;
        vectors = 0; miscompares = 0;
        par_rst = 1'b1; tube_nrst = 1'b1;
        tx_data = '0; tx_valid = '0; rx_ready = '0;
        for (int n = 0; n < 4; n++) begin stat[n] = 8'h00; dbyte[n] = 8'h00; end
        tick();

        for (int s = 0; s < 12; s++) begin
            for (int n = 0; n < 4; n++) begin
                stat[n]  = 8'($urandom);
                dbyte[n] = 8'($urandom);
            end
            tx_data  = $urandom;
            tx_valid = 4'($urandom);
            rx_ready = 4'($urandom);
            if (s < 4) begin
                for (int n = 0; n < 4; n++) stat[n] = 8'h00;
                tx_valid = 4'b0;
                rx_ready = 4'b0;
            end
            case (s)
                0: begin stat[0] = 8'h80; dbyte[0] = 8'hA5; end
                1: stat[0] = 8'hC0;
                2: begin stat[2] = 8'h40; tx_valid = 4'b0100; tx_data[23:16] = 8'h3C; end
                3: begin stat[3] = 8'h00; tx_valid = 4'b1000; end
                default: ;
            endcase

            reset_dut(s[0]);
            release_rst();

            if (s == 0) begin
                b = 0;
                while (!(bus0.tube_ncs == 1'b0 && bus0.tube_addr == 3'd1) && b < 50) begin
                    tick();
                    b++;
                end
                chk("reach S_RD", 64'(b < 50), 64'd1);
                reset_dut(1'b0);
                release_rst();
            end

            build(M0, G0); exp0 = mq; rseen0 = rs;
            build(M1, G1); exp1 = mq; rseen1 = rs;

            b = 0;
            while ((obs0.size() < K || obs1.size() < K) && b < 300) begin
                tick();
                b++;
            end
            chk("access budget", 64'(b < 300), 64'd1);
            tick();
            tick();

            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    oq = obs0; eq = exp0; rs = rseen0; rxv = rx_valid0; rxd = rx_data0; rl = rxl0; st = stray0;
                end else begin
                    oq = obs1; eq = exp1; rs = rseen1; rxv = rx_valid1; rxd = rx_data1; rl = rxl1; st = stray1;
                end
                for (int i = 0; i < K && i < oq.size(); i++) begin
                    a = oq[i];
                    a.t = a.t - oq[0].t;
                    chk($sformatf("access s%0d d%0d #%0d", s, d, i), 64'(a), 64'(eq[i]));
                end
                chk($sformatf("tx_ready without write s%0d d%0d", s, d), 64'(st), 64'd0);
                for (int n = 0; n < 4; n++)
                    if (!rx_ready[n] && rs[n])
                        chk($sformatf("rx hold s%0d d%0d ch%0d", s, d, n),
                            {rxv[n], rxd[8*n +: 8]}, {1'b1, dbyte[n]});
                for (int i = 0; i < rl.size(); i++)
                    chk($sformatf("rx consume s%0d d%0d", s, d), 64'(rl[i][7:0]), 64'(dbyte[rl[i][9:8]]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
